data_memory_line_fill_unit: RTL and testbench
=============================================

DATA_MEMORY_LINE_FILL_UNIT -- requirements
Module: data_memory_line_fill_unit

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning):
- XLEN, 32, address width
- PORT_WIDTH, 32, data word width
- BLOCK_WIDTH, 128, cache line width; BLOCK_WIDTH/PORT_WIDTH = WORDS = 4
- TIMEOUT, 255, maximum cycles to wait for one memory word
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk_i in 1 single clock; all logic on rising edge
- rst_i in 1 synchronous reset, active-high
- processor_request_i in 1 line fill request from the load cache controller
- processor_address_i in XLEN miss address
- external_acknowledge_o out 1 request accepted
- external_data_o out PORT_WIDTH line word toward the cache controller
- external_data_valid_o out 1 external_data_o valid
- cache_line_valid_o out 1 full line delivered
- line_done_i in 1 cache controller finished allocating the line
- mem_read_o out 1 word read request to memory
- mem_address_o out XLEN word address
- mem_ready_i in 1 memory accepts mem_read_o
- mem_data_i in PORT_WIDTH memory read data
- mem_data_valid_i in 1 mem_data_i valid
- bus_error_o out 1 one-cycle timeout indication
- idle_o out 1 FSM in IDLE

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT_DATA, LINE_VALID.
REQ-004 In IDLE, processor_request_i sampled high SHALL latch the line base address (processor_address_i with low log2(BLOCK_WIDTH/8) bits cleared), clear the word counter, and enter ISSUE.
REQ-005 external_acknowledge_o SHALL be high for exactly the first cycle spent in ISSUE after an accepted request (registered, one cycle after sampling).
REQ-006 processor_request_i outside IDLE SHALL be ignored; no acknowledge is generated.
REQ-007 In ISSUE, mem_read_o SHALL be high with mem_address_o = base + word_count*(PORT_WIDTH/8); held stable until mem_ready_i sampled high, then enter WAIT_DATA.
REQ-008 One memory read SHALL be outstanding at a time; words SHALL be fetched in ascending order, word 0 first.
REQ-009 In WAIT_DATA, mem_data_valid_i sampled high SHALL register mem_data_i into external_data_o and assert external_data_valid_o for exactly the next cycle; word counter increments.
REQ-010 After word WORDS-1 is received the FSM SHALL enter LINE_VALID; otherwise it SHALL return to ISSUE.
REQ-011 In LINE_VALID, cache_line_valid_o SHALL be high continuously until line_done_i sampled high, then the FSM SHALL enter IDLE; external_data_valid_o and cache_line_valid_o SHALL never be high in the same cycle.
REQ-012 A timeout counter SHALL clear on entering WAIT_DATA and increment each WAIT_DATA cycle without mem_data_valid_i; on reaching TIMEOUT the FSM SHALL pulse bus_error_o one cycle and go to IDLE without asserting cache_line_valid_o.
REQ-013 mem_data_valid_i in the same cycle the counter reaches TIMEOUT SHALL be treated as valid data; no error.
REQ-014 mem_data_valid_i outside WAIT_DATA SHALL be ignored.
REQ-015 The word counter SHALL be log2(WORDS) bits and SHALL never wrap inside one line.
REQ-016 idle_o SHALL be high exactly when the current state is IDLE.
REQ-017 external_data_o SHALL hold its last value when external_data_valid_o is low.

Reset
REQ-018 rst_i high at a clock edge SHALL force IDLE, clear counters and address, and drive all outputs low (idle_o high) from the next cycle, including mid-fill; partially fetched words are discarded.
REQ-019 A request present in the reset cycle SHALL NOT be accepted.

Verification
REQ-020 Request addr 0x0000_1234, mem_ready_i and mem_data_valid_i always one cycle later -> ack one cycle after request; mem_address_o 0x1230, 0x1234, 0x1238, 0x123C in order; four data pulses; then cache_line_valid_o until line_done_i.
REQ-021 mem_ready_i held low 5 cycles on word 2 -> mem_read_o and mem_address_o 0x1238 stable all 5 cycles; no extra reads.
REQ-022 No mem_data_valid_i after word 1 request, TIMEOUT=255 -> bus_error_o single pulse 255 cycles after entering WAIT_DATA; FSM IDLE; cache_line_valid_o never high.
REQ-023 Second request asserted during LINE_VALID -> no ack until line_done_i and return to IDLE; then accepted normally.
REQ-024 rst_i asserted after word 2 delivered -> next cycle all outputs low, idle_o high; new request fetches from word 0.
REQ-025 mem_data_valid_i coincident with timeout terminal count -> data forwarded, no bus_error_o.

Source files
------------

// File: rtl/data_memory_line_fill_unit.sv
// Line fill unit: on a load miss, fetches one cache line from memory one
// word at a time (ascending order) and streams the words to the cache
// controller, then holds cache_line_valid_o until the controller is done.
// A per-word timeout aborts the fill with a one-cycle bus_error_o pulse.
//
// Handshake semantics: mem_read_o/mem_address_o are held stable while in
// ISSUE and a transfer happens on a rising edge where mem_read_o and
// mem_ready_i are both high. mem_data_valid_i is honoured only while a read
// is outstanding (WAIT_DATA) and is ignored at any other time.
// external_data_valid_o is a one-cycle strobe that qualifies
// external_data_o; there is no back-pressure on it.
module data_memory_line_fill_unit #(
  parameter int XLEN        = 32,
  parameter int PORT_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  processor_request_i,
  input  logic [XLEN-1:0]       processor_address_i,
  output logic                  external_acknowledge_o,
  output logic [PORT_WIDTH-1:0] external_data_o,
  output logic                  external_data_valid_o,
  output logic                  cache_line_valid_o,
  input  logic                  line_done_i,
  output logic                  mem_read_o,
  output logic [XLEN-1:0]       mem_address_o,
  input  logic                  mem_ready_i,
  input  logic [PORT_WIDTH-1:0] mem_data_i,
  input  logic                  mem_data_valid_i,
  output logic                  bus_error_o,
  output logic                  idle_o
);

  localparam int WORDS = BLOCK_WIDTH / PORT_WIDTH;
  localparam int CNT_W = $clog2(WORDS);
  localparam int WOFF  = $clog2(PORT_WIDTH / 8);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(BLOCK_WIDTH / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_DATA  = 2'd2,
    S_LINE_VALID = 2'd3
  } state_t;

  // state_q is the observable FSM state for checkers bound to this block.
  state_t                  state_q, state_d;
  logic [XLEN-1:0]         base_q;
  logic [CNT_W-1:0]        word_cnt_q;
  logic [TO_W-1:0]         timeout_q;
  logic                    ack_q;
  logic [PORT_WIDTH-1:0]   data_q;
  logic                    data_valid_q;
  logic                    bus_error_q;

  logic                    accept;
  logic                    word_done;
  logic                    timeout_hit;
  logic                    last_word;
  logic [XLEN-1:0]         word_offset;

  assign last_word   = (word_cnt_q == CNT_W'(WORDS - 1));
  assign word_offset = {{(XLEN-CNT_W){1'b0}}, word_cnt_q} << WOFF;

  // Next-state and per-cycle event decode.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    word_done   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (processor_request_i) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready_i) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        // Data arriving on the last allowed cycle wins over the timeout.
        if (mem_data_valid_i) begin
          word_done = 1'b1;
          state_d   = last_word ? S_LINE_VALID : S_ISSUE;
        end else if (timeout_q == TO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_LINE_VALID: begin
        // The first LINE_VALID cycle carries the last data strobe, so
        // line_done_i only counts once cache_line_valid_o is visible.
        if (line_done_i && !data_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: line base, word/timeout counters and registered strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q       <= '0;
      word_cnt_q   <= '0;
      timeout_q    <= '0;
      ack_q        <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      ack_q        <= accept;
      data_valid_q <= word_done;
      bus_error_q  <= timeout_hit;
      if (accept) begin
        base_q     <= processor_address_i & LINE_MASK;
        word_cnt_q <= '0;
      end
      if (word_done) begin
        data_q <= mem_data_i;
        if (!last_word) word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (state_q == S_ISSUE && mem_ready_i) begin
        timeout_q <= '0;
      end else if (state_q == S_WAIT_DATA && !mem_data_valid_i) begin
        timeout_q <= timeout_q + 1'b1;
      end
    end
  end

  assign external_acknowledge_o = ack_q;
  assign external_data_o        = data_q;
  assign external_data_valid_o  = data_valid_q;
  assign cache_line_valid_o     = (state_q == S_LINE_VALID) && !data_valid_q;
  assign mem_read_o             = (state_q == S_ISSUE);
  assign mem_address_o          = (state_q == S_ISSUE) ? (base_q + word_offset) : '0;
  assign bus_error_o            = bus_error_q;
  assign idle_o                 = (state_q == S_IDLE);

endmodule

// File: tb/tb_data_memory_line_fill_unit.sv
// Bench for data_memory_line_fill_unit: directed scenarios plus randomized
// line fills with random memory latencies and ignored-input noise.
module tb_data_memory_line_fill_unit;

  logic        clk;
  logic        rst;
  logic        proc_req;
  logic [31:0] proc_addr;
  logic        ack;
  logic [31:0] ext_data;
  logic        ext_valid;
  logic        line_valid;
  logic        line_done;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        mem_dvalid;
  logic        bus_err;
  logic        idle;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_data;
  logic [31:0] exp_base;

  data_memory_line_fill_unit dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .processor_request_i    (proc_req),
    .processor_address_i    (proc_addr),
    .external_acknowledge_o (ack),
    .external_data_o        (ext_data),
    .external_data_valid_o  (ext_valid),
    .cache_line_valid_o     (line_valid),
    .line_done_i            (line_done),
    .mem_read_o             (mem_read),
    .mem_address_o          (mem_addr),
    .mem_ready_i            (mem_ready),
    .mem_data_i             (mem_data),
    .mem_data_valid_i       (mem_dvalid),
    .bus_error_o            (bus_err),
    .idle_o                 (idle)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Line base from the miss address: 16-byte aligned.
  function automatic logic [31:0] line_base(input logic [31:0] a);
    return (a / 32'd16) * 32'd16;
  endfunction

  task automatic start_req(input logic [31:0] a);
    check("idle_before_req", idle, 1);
    proc_req  = 1'b1;
    proc_addr = a;
    exp_base  = line_base(a);
    tick();
    proc_req = 1'b0;
    check("ack_after_req", ack, 1);
    check("idle_after_req", idle, 0);
  endtask

  // ISSUE phase of word k; memory accepts after lat stall cycles.
  task automatic issue_word(input int k, input int lat);
    for (int i = 0; i <= lat; i++) begin
      check("mem_read_issue", mem_read, 1);
      check("mem_addr", mem_addr, exp_base + 32'(4 * k));
      check("ack_issue", ack, (k == 0 && i == 0) ? 1 : 0);
      check("data_hold_issue", ext_data, last_data);
      check("line_valid_issue", line_valid, 0);
      if (i > 0) check("dvalid_issue", ext_valid, 0);
      mem_ready  = (i == lat);
      mem_dvalid = 1'($urandom_range(0, 1));
      mem_data   = $urandom;
      proc_req   = 1'($urandom_range(0, 1));
      tick();
    end
    mem_ready  = 1'b0;
    mem_dvalid = 1'b0;
    proc_req   = 1'b0;
  endtask

  // WAIT_DATA phase of word k; data arrives after lat empty cycles.
  task automatic data_word(input int k, input int lat);
    logic [31:0] w;
    logic [31:0] e;
    w = $urandom;
    exp_q.push_back(w);
    for (int i = 0; i <= lat; i++) begin
      check("mem_read_wait", mem_read, 0);
      check("dvalid_wait", ext_valid, 0);
      check("data_hold_wait", ext_data, last_data);
      check("bus_err_wait", bus_err, 0);
      check("ack_wait", ack, 0);
      mem_dvalid = (i == lat);
      mem_data   = (i == lat) ? w : $urandom;
      mem_ready  = 1'($urandom_range(0, 1));
      proc_req   = 1'($urandom_range(0, 1));
      tick();
    end
    mem_dvalid = 1'b0;
    mem_ready  = 1'b0;
    proc_req   = 1'b0;
    mem_data   = $urandom;
    e = exp_q.pop_front();
    check($sformatf("dvalid_word%0d", k), ext_valid, 1);
    check($sformatf("data_word%0d", k), ext_data, e);
    check("line_valid_with_data", line_valid, 0);
    check("bus_err_data", bus_err, 0);
    last_data = e;
  endtask

  // LINE_VALID phase: held for 'hold' cycles, then line_done_i.
  task automatic finish_line(input int hold, input logic keep_req, input logic [31:0] next_a);
    proc_req  = keep_req;
    proc_addr = next_a;
    line_done = 1'b0;
    tick();
    for (int i = 0; i < hold; i++) begin
      check("line_valid_hold", line_valid, 1);
      check("dvalid_line", ext_valid, 0);
      check("ack_line", ack, 0);
      check("idle_line", idle, 0);
      check("mem_read_line", mem_read, 0);
      line_done = (i == hold - 1);
      tick();
    end
    line_done = 1'b0;
    check("idle_after_done", idle, 1);
    check("line_valid_after_done", line_valid, 0);
    check("ack_after_done", ack, 0);
  endtask

  task automatic fill_line(input logic [31:0] a, input int max_rdy, input int max_dat,
                           input int hold, input logic keep_req, input logic [31:0] next_a);
    start_req(a);
    for (int k = 0; k < 4; k++) begin
      issue_word(k, $urandom_range(0, max_rdy));
      data_word(k, $urandom_range(0, max_dat));
    end
    finish_line(hold, keep_req, next_a);
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", ack, 0);
    check("rst_data", ext_data, 0);
    check("rst_dvalid", ext_valid, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_idle", idle, 1);
  endtask

  initial begin
    // Reset
    rst = 1'b1; proc_req = 1'b0; proc_addr = '0; line_done = 1'b0;
    mem_ready = 1'b0; mem_data = '0; mem_dvalid = 1'b0;
    last_data = '0; exp_base = '0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_outputs();

    // Basic fill at 0x1234, memory answers immediately.
    start_req(32'h0000_1234);
    for (int k = 0; k < 4; k++) begin
      issue_word(k, 0);
      data_word(k, 0);
    end
    finish_line(3, 1'b0, 32'h0);

    // Memory stalls 5 cycles on word 2.
    start_req(32'h2000_004C);
    for (int k = 0; k < 4; k++) begin
      issue_word(k, (k == 2) ? 5 : 0);
      data_word(k, 1);
    end
    finish_line(1, 1'b0, 32'h0);

    // Second request held during LINE_VALID, accepted after return to IDLE.
    fill_line(32'h0000_8008, 2, 3, 4, 1'b1, 32'h0000_9FFC);
    fill_line(32'h0000_9FFC, 2, 3, 2, 1'b0, 32'h0);

    // Data coincident with the last allowed wait cycle is accepted.
    start_req(32'h0ABC_0010);
    issue_word(0, 0);
    data_word(0, 254);
    for (int k = 1; k < 4; k++) begin
      issue_word(k, 1);
      data_word(k, 2);
    end
    finish_line(2, 1'b0, 32'h0);

    // Timeout on word 1: 255 empty wait cycles, then one bus_error pulse.
    start_req(32'h0000_4440);
    issue_word(0, 0);
    data_word(0, 0);
    issue_word(1, 0);
    for (int c = 0; c < 255; c++) begin
      check("bus_err_before_to", bus_err, 0);
      check("idle_before_to", idle, 0);
      check("line_valid_to", line_valid, 0);
      tick();
    end
    check("bus_err_pulse", bus_err, 1);
    check("idle_after_to", idle, 1);
    check("line_valid_after_to", line_valid, 0);
    mem_dvalid = 1'b1;
    mem_data   = 32'hDEAD_BEEF;
    tick();
    mem_dvalid = 1'b0;
    check("bus_err_one_cycle", bus_err, 0);
    check("idle_ignore_dvalid", idle, 1);
    check("dvalid_in_idle", ext_valid, 0);
    check("line_valid_post_to", line_valid, 0);

    // Reset after word 2 delivered; request during reset is dropped.
    start_req(32'h0000_7770);
    for (int k = 0; k < 3; k++) begin
      issue_word(k, $urandom_range(0, 2));
      data_word(k, $urandom_range(0, 3));
    end
    rst = 1'b1;
    proc_req = 1'b1;
    tick();
    rst = 1'b0;
    proc_req = 1'b0;
    last_data = '0;
    check_reset_outputs();
    tick();
    check("ack_after_rst_req", ack, 0);
    check("idle_after_rst_req", idle, 1);
    fill_line(32'h0000_7774, 1, 2, 1, 1'b0, 32'h0);

    // Randomized fills.
    for (int n = 0; n < 8; n++) begin
      fill_line($urandom, 3, 6, $urandom_range(1, 4), 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
